// File: rtl/display_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// display_refresh_ctrl
// Two-digit seven-segment refresh controller. A prescaler divides clk down to
// a refresh step. A 5-bit refresh counter walks both digit slots, and count[4]
// selects digit0. The anodes are driven active-low in the middle of each slot,
// with GUARD blanking steps at either end of the slot. A one-entry pending
// buffer takes new display values. A new value becomes the displayed char only
// when the counter wraps, so a frame never shows a half-updated value.
// -----------------------------------------------------------------------------
module display_refresh_ctrl #(
    parameter int unsigned DIV   = 16,  // clk cycles per refresh step (2..65535)
    parameter int unsigned GUARD = 2    // blanking steps at each slot end (0..7)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] char,
    output logic [4:0] count,
    output logic       an0,
    output logic       an1,
    output logic       frame_tick
);

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

    // A slot position lights its digit only between the two guard bands.
    // Signed arithmetic keeps the upper bound meaningful for any GUARD: with
    // GUARD >= 8 the window is empty and the display stays blank.
    function automatic logic slot_active(input logic [3:0] pos);
        int p;
        p = int'(pos);
        return (p >= int'(GUARD)) && (p <= 15 - int'(GUARD));
    endfunction

    logic [15:0] presc_q, presc_d;
    logic [4:0]  count_q, count_d;
    logic        an0_q, an0_d;
    logic        an1_q, an1_d;
    logic        tick_q, tick_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        pend_valid_q, pend_valid_d;

    logic        step;
    logic        wrap;
    logic        accept;

    // Refresh timing: prescaler, counter step, wrap detect and next anode state.
    always_comb begin
        // NOTE: every signal this block drives gets a default value first.
        // Without the default, a path that skips an assignment would infer a latch.
        step    = 1'b0;
        wrap    = 1'b0;
        presc_d = presc_q + 16'd1;
        count_d = count_q;
        if (presc_q == PRESC_LAST) begin
            step    = 1'b1;
            presc_d = '0;
            count_d = count_q + 5'd1;
            wrap    = (count_q == 5'd31);
        end
        // The anodes are decoded from the next count, so once registered they
        // change on the same edge as the count value they belong to.
        an0_d  = ~(count_d[4] & slot_active(count_d[3:0]));
        an1_d  = ~(~count_d[4] & slot_active(count_d[3:0]));
        tick_d = wrap;
    end

    // Pending buffer and displayed value: accept when empty, publish on wrap.
    always_comb begin
        accept       = in_valid & ~pend_valid_q;
        char_d       = char_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        if (wrap && pend_valid_q) begin
            char_d       = pend_data_q;
            pend_valid_d = 1'b0;
        end
        // An accept can only happen while the buffer was empty. On a wrap in
        // that same cycle there is nothing to publish, so the new value waits
        // for the next wrap.
        if (accept) begin
            pend_data_d  = in_char;
            pend_valid_d = 1'b1;
        end
    end

    // State registers, asynchronously cleared to the blank/idle state.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments. All flops then
        // sample their _d values together and no update order is implied.
        if (!resetn) begin
            presc_q      <= '0;
            count_q      <= '0;
            an0_q        <= 1'b1;
            an1_q        <= 1'b1;
            tick_q       <= 1'b0;
            char_q       <= 8'h00;
            pend_data_q  <= 8'h00;
            pend_valid_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            count_q      <= count_d;
            an0_q        <= an0_d;
            an1_q        <= an1_d;
            tick_q       <= tick_d;
            char_q       <= char_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // in_ready is the only output with a combinational term. It depends on
    // local state and not on the in_* inputs. It reads 1 while in reset.
    assign in_ready   = ~pend_valid_q;
    assign char       = char_q;
    assign count      = count_q;
    assign an0        = an0_q;
    assign an1        = an1_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/display_refresh_ctrl.md
DISPLAY_REFRESH_CTRL -- requirements
Module: display_refresh_ctrl

Interface
REQ-001 Parameter DIV, default 16: clk cycles per refresh-counter step; legal range 2..65535.
REQ-002 Parameter GUARD, default 2: blanking steps at each end of a digit slot; legal range 0..7.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 in_char  input  8  new display value; [7:4] is digit0, [3:0] is digit1.
REQ-006 in_valid  input  1  in_char is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_char this cycle.
REQ-008 char  output  8  displayed value; feeds the seven-segment driver char input.
REQ-009 count  output  5  refresh counter; feeds driver count; count[4]=1 selects digit0.
REQ-010 an0  output  1  digit0 anode enable, active-low.
REQ-011 an1  output  1  digit1 anode enable, active-low.
REQ-012 frame_tick  output  1  one-cycle pulse when count wraps 31->0.

Function
REQ-013 Prescaler counts 0..DIV-1 and wraps; step strobe is asserted in the cycle the prescaler equals DIV-1.
REQ-014 On step strobe, count increments by 1 modulo 32; otherwise count holds.
REQ-015 Slot position is pos = count[3:0]; a slot is active when GUARD <= pos <= 15-GUARD.
REQ-016 an0 = 0 iff count[4]=1 and slot active; an1 = 0 iff count[4]=0 and slot active; otherwise 1.
REQ-017 an0 and an1 are never 0 in the same cycle.
REQ-018 an0/an1 are registered and change in the same cycle as the count value they correspond to; no combinational path from in_* to any output except in_ready.
REQ-019 One-entry pending buffer (pend_data[7:0], pend_valid).
REQ-020 in_ready = ~pend_valid (combinational).
REQ-021 Accept occurs when in_valid=1 and in_ready=1: pend_data <= in_char, pend_valid <= 1.
REQ-022 Wrap event: step strobe while count=31; frame_tick is asserted in the same cycle count becomes 0.
REQ-023 On a wrap event with pend_valid=1: char <= pend_data and pend_valid <= 0; char changes only at wrap events.
REQ-024 On a simultaneous accept and wrap with pend_valid=0: the wrap updates nothing; the accepted data enters pending and is displayed at the next wrap.
REQ-025 While pend_valid=1, in_valid is ignored and in_char is not sampled.
REQ-026 Multiple accepts between wraps are impossible; at most one new value is displayed per frame.
REQ-027 Frame period = 32*DIV clk cycles; digit-slot period = 16*DIV cycles.
REQ-028 With GUARD >= 8 both anodes stay at 1 (display blank); this condition is legal but unused.

Reset
REQ-029 resetn=0 asynchronously forces: prescaler=0, count=0, char=8'h00, pend_valid=0, pend_data=8'h00, an0=1, an1=1, frame_tick=0.
REQ-030 While reset is asserted, in_ready is 1; accepts during reset are discarded.
REQ-031 Reset asserted mid-frame discards the pending value and restarts counting at count=0, with the prescaler at 0 on the first edge after release.
REQ-032 After release, the first step strobe occurs DIV cycles after the first active clk edge.

Verification
REQ-033 DIV=4, GUARD=2, no input: count steps every 4 cycles; an1=0 only for count 2..13, an0=0 only for count 18..29; frame_tick pulses every 128 cycles.
REQ-034 Write in_char=8'hA5 at count=5: in_ready drops next cycle; char stays 8'h00 until count wraps to 0, then char=8'hA5, frame_tick=1, in_ready=1.
REQ-035 Second write 8'h3C while pending is set: it is not accepted (in_ready=0); after the wrap, char=8'hA5; writing 8'h3C again is accepted and displayed at the following wrap.
REQ-036 in_valid with 8'h7E in the exact wrap cycle, pending empty: char is unchanged at this wrap; char=8'h7E at the next wrap (128 cycles later at DIV=4).
REQ-037 resetn pulsed low at count=20 with 8'h11 pending: all outputs return to reset values immediately; 8'h11 is never displayed.
REQ-038 Every cycle (assertion): never an0=0 and an1=0 together; char changes only in frame_tick cycles.
